ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
- Instruction fetch unit for the multicycle core; the transmitting end of the fetch→decode handshake.
- Holds the architectural PC and issues one fetch request per instruction on the instruction-memory request/response bus.
- Presents the fetched word to decode with a valid/ready handshake, then waits for the next PC from the execute/writeback stage before fetching again.
- Exactly one instruction is in flight at a time.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset
CNT_W, 64, width of retired-fetch counter

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-low
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request this cycle
imem_addr  out  32  fetch address (= pc)
imem_rsp_valid  in  1  response valid
imem_rsp_data  in  32  fetched instruction word
imem_rsp_err  in  1  bus error on this response
real_ins  out  32  instruction to decode
ifu_valid  out  1  real_ins valid
idu_ready  in  1  decode can accept
pc  out  32  PC of current instruction
pc_update_valid  in  1  next PC available (instruction completed)
next_pc  in  32  next PC value
fetch_fault  out  1  sticky fault flag
fetch_count  out  CNT_W  instructions handed to decode

Behaviour:
- Reset (rst low, async): state=REQ; pc=RESET_PC; real_ins=0; ifu_valid=0; fetch_fault=0; fetch_count=0. imem_req_valid=1 in the first clock after rst deasserts.
- States: REQ, WAIT_RSP, VALID, WAIT_PC, FAULT.
- REQ: imem_req_valid=1, imem_addr=pc. Valid and addr hold until imem_req_ready=1, then go to WAIT_RSP.
- WAIT_RSP: imem_req_valid=0. A response with imem_rsp_valid=1 and err=0 latches real_ins=imem_rsp_data, sets ifu_valid=1 at the next edge, and moves to VALID. Minimum latency from accepted request to ifu_valid is therefore 2 cycles when the response arrives on the following cycle. With imem_rsp_err=1, move to FAULT.
- VALID: ifu_valid=1. real_ins and pc stay stable until a transfer (ifu_valid & idu_ready). On transfer: ifu_valid=0 at the next edge, fetch_count+1, move to WAIT_PC.
- WAIT_PC: wait for pc_update_valid.
  - If next_pc[1:0]==0: pc=next_pc, move to REQ; the request is visible the cycle after the update.
  - If next_pc[1:0]!=0: move to FAULT and leave pc unchanged.
- FAULT: fetch_fault=1 (sticky), ifu_valid=0, imem_req_valid=0. Only reset exits this state.
- pc_update_valid outside WAIT_PC is ignored.
- imem_rsp_valid outside WAIT_RSP is ignored.
- A response in the same cycle the request is accepted is not accepted; responses are taken only in WAIT_RSP.
- fetch_count wraps modulo 2^CNT_W.
- real_ins retains its last value when ifu_valid=0. Decode masks it.
- Reset asserted mid-operation (any state, including an outstanding request) returns to the reset values immediately. A late response after reset release is dropped, because the state is REQ and not WAIT_RSP.
- idu_ready held high continuously is legal; only one transfer occurs per fetched word.

Test Plan:
- Reset release, imem_req_ready=1, response 0x00000013 one cycle later: imem_addr=0x80000000. ifu_valid rises 2 cycles after request acceptance with real_ins=0x00000013. idu_ready=1 then gives fetch_count=1 and ifu_valid=0.
- Hold imem_req_ready=0 for 5 cycles: imem_req_valid stays 1 and imem_addr stays 0x80000000 throughout; exactly one request is accepted.
- Hold idu_ready=0 for 4 cycles in VALID: real_ins and pc remain constant and fetch_count does not increment. pc_update_valid=1 pulsed during this window causes no PC change.
- Transfer, then pc_update_valid with next_pc=0x80000010: next request has imem_addr=0x80000010. Same with next_pc=0x80000012: fetch_fault=1, no further requests, pc stays 0x80000000.
- Response with imem_rsp_err=1: FAULT state, fetch_fault=1, ifu_valid stays 0. Then assert rst low for 1 cycle: fetch_fault=0, pc=0x80000000, request reissued.
- Assert rst in WAIT_RSP, then release with a stray imem_rsp_valid in the first cycle: the stray response is ignored, and a fresh request goes out to 0x80000000.

Source files
------------

// File: rtl/ifu_fetch_if.sv
// Fetch-unit signal bundle: instruction-memory request/response bus, decode
// handshake, next-PC update from execute/writeback, and fetch status.
interface ifu_fetch_if #(
    parameter int CNT_W = 64
);
    logic             imem_req_valid;
    logic             imem_req_ready;
    logic [31:0]      imem_addr;
    logic             imem_rsp_valid;
    logic [31:0]      imem_rsp_data;
    logic             imem_rsp_err;
    logic [31:0]      real_ins;
    logic             ifu_valid;
    logic             idu_ready;
    logic [31:0]      pc;
    logic             pc_update_valid;
    logic [31:0]      next_pc;
    logic             fetch_fault;
    logic [CNT_W-1:0] fetch_count;

    // The fetch unit drives requests, the decode word and status.
    modport master (
        output imem_req_valid, imem_addr, real_ins, ifu_valid, pc,
               fetch_fault, fetch_count,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
               idu_ready, pc_update_valid, next_pc
    );

    modport slave (
        input  imem_req_valid, imem_addr, real_ins, ifu_valid, pc,
               fetch_fault, fetch_count,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
               idu_ready, pc_update_valid, next_pc
    );
endinterface

// File: rtl/ifu_fetch.sv
// Multicycle instruction fetch: one request in flight, word handed to decode
// over valid/ready, then waits for the next PC. Faults are sticky until reset.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          CNT_W    = 64
) (
    input  logic         clk,
    input  logic         rst,
    ifu_fetch_if.master  bus
);

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT_RSP,
        S_VALID,
        S_WAIT_PC,
        S_FAULT
    } state_e;

    state_e           state_q;
    logic [31:0]      pc_q;
    logic [31:0]      ins_q;
    logic             req_valid_q;
    logic             ifu_valid_q;
    logic             fault_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign count_d = count_q + CNT_W'(1);

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            ins_q       <= '0;
            req_valid_q <= 1'b1;
            ifu_valid_q <= 1'b0;
            fault_q     <= 1'b0;
            count_q     <= '0;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (bus.imem_req_ready) begin
                        req_valid_q <= 1'b0;
                        state_q     <= S_WAIT_RSP;
                    end
                end

                // Responses are only looked at here, so stray or late ones elsewhere are dropped.
                S_WAIT_RSP: begin
                    if (bus.imem_rsp_valid) begin
                        if (bus.imem_rsp_err) begin
                            fault_q <= 1'b1;
                            state_q <= S_FAULT;
                        end else begin
                            ins_q       <= bus.imem_rsp_data;
                            ifu_valid_q <= 1'b1;
                            state_q     <= S_VALID;
                        end
                    end
                end

                S_VALID: begin
                    if (bus.idu_ready) begin
                        ifu_valid_q <= 1'b0;
                        count_q     <= count_d;
                        state_q     <= S_WAIT_PC;
                    end
                end

                // A misaligned target faults without disturbing the architectural PC.
                S_WAIT_PC: begin
                    if (bus.pc_update_valid) begin
                        if (bus.next_pc[1:0] == 2'b00) begin
                            pc_q        <= bus.next_pc;
                            req_valid_q <= 1'b1;
                            state_q     <= S_REQ;
                        end else begin
                            fault_q <= 1'b1;
                            state_q <= S_FAULT;
                        end
                    end
                end

                S_FAULT: begin
                    fault_q     <= 1'b1;
                    ifu_valid_q <= 1'b0;
                    req_valid_q <= 1'b0;
                end

                default: begin
                    fault_q     <= 1'b1;
                    ifu_valid_q <= 1'b0;
                    req_valid_q <= 1'b0;
                    state_q     <= S_FAULT;
                end
            endcase
        end
    end

    assign bus.imem_req_valid = req_valid_q;
    assign bus.imem_addr      = pc_q;
    assign bus.real_ins       = ins_q;
    assign bus.ifu_valid      = ifu_valid_q;
    assign bus.pc             = pc_q;
    assign bus.fetch_fault    = fault_q;
    assign bus.fetch_count    = count_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: a transaction model predicts fetch addresses and decode
// transfers; a negedge monitor pops and compares them as the DUT presents them.
module tb_ifu_fetch;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int          CNT_W    = 64;

    typedef struct {
        logic [31:0]      pc;
        logic [31:0]      ins;
        logic [CNT_W-1:0] cnt;
    } dec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    ifu_fetch_if #(.CNT_W(CNT_W)) bus ();

    ifu_fetch #(
        .RESET_PC (RESET_PC),
        .CNT_W    (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: architectural view of the fetch stream.
    logic [31:0]      model_pc  = RESET_PC;
    logic [31:0]      model_ins = '0;
    logic [CNT_W-1:0] model_cnt = '0;

    logic [31:0] exp_req_q[$];
    dec_t        exp_dec_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit coin(input int n);
        return $urandom_range(0, n - 1) == 0;
    endfunction

    // Monitor: compares every request acceptance and every decode transfer.
    initial begin
        dec_t d;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (bus.imem_req_valid && bus.imem_req_ready) begin
                    if (exp_req_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL req_unexpected: request to 0x%0h, none expected", bus.imem_addr);
                    end else begin
                        check("req_addr", bus.imem_addr, exp_req_q.pop_front());
                    end
                end
                if (bus.ifu_valid && bus.idu_ready) begin
                    if (exp_dec_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL dec_unexpected: transfer of 0x%0h, none expected", bus.real_ins);
                    end else begin
                        d = exp_dec_q.pop_front();
                        check("dec_ins", bus.real_ins, d.ins);
                        check("dec_pc", bus.pc, d.pc);
                        check("dec_count", bus.fetch_count, d.cnt);
                    end
                end
            end
        end
    end

    // All tasks start and end at posedge+1: outputs are settled, inputs may change.
    task automatic do_reset(input int hold, input bit stray);
        rst = 1'b0;
        bus.imem_req_ready  = 1'b0;
        bus.imem_rsp_valid  = 1'b0;
        bus.imem_rsp_err    = 1'b0;
        bus.idu_ready       = 1'b0;
        bus.pc_update_valid = 1'b0;
        #1;
        check("rst_pc", bus.pc, RESET_PC);
        check("rst_ifu_valid", bus.ifu_valid, 0);
        check("rst_real_ins", bus.real_ins, 0);
        check("rst_fault", bus.fetch_fault, 0);
        check("rst_count", bus.fetch_count, 0);
        exp_req_q.delete();
        exp_dec_q.delete();
        model_pc  = RESET_PC;
        model_ins = '0;
        model_cnt = '0;
        exp_req_q.push_back(RESET_PC);
        repeat (hold) @(posedge clk);
        #1;
        rst = 1'b1;
        if (stray) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = $urandom;
            @(posedge clk); #1;
            bus.imem_rsp_valid = 1'b0;
            check("stray_ifu_valid", bus.ifu_valid, 0);
            check("stray_req_valid", bus.imem_req_valid, 1);
            check("stray_req_addr", bus.imem_addr, RESET_PC);
        end
    endtask

    task automatic do_request(input int ready_delay);
        check("req_valid_start", bus.imem_req_valid, 1);
        check("req_addr_start", bus.imem_addr, model_pc);
        for (int i = 0; i < ready_delay; i++) begin
            bus.imem_req_ready = 1'b0;
            bus.imem_rsp_valid = coin(2);
            bus.imem_rsp_err   = coin(4);
            bus.imem_rsp_data  = $urandom;
            @(posedge clk); #1;
            check("req_hold_valid", bus.imem_req_valid, 1);
            check("req_hold_addr", bus.imem_addr, model_pc);
        end
        // A response offered alongside acceptance must be ignored.
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = coin(2);
        bus.imem_rsp_err   = coin(4);
        bus.imem_rsp_data  = $urandom;
        @(posedge clk); #1;
        bus.imem_req_ready = coin(2);
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_err   = 1'b0;
        check("req_drop_valid", bus.imem_req_valid, 0);
        check("req_no_early_ins", bus.ifu_valid, 0);
        check("req_no_early_fault", bus.fetch_fault, 0);
    endtask

    task automatic do_response(input int delay, input logic [31:0] data, input bit err);
        for (int i = 0; i < delay; i++) begin
            bus.imem_rsp_valid  = 1'b0;
            bus.imem_rsp_data   = $urandom;
            bus.pc_update_valid = coin(2);
            bus.next_pc         = $urandom;
            bus.imem_req_ready  = coin(2);
            @(posedge clk); #1;
            check("rsp_wait_valid", bus.ifu_valid, 0);
            check("rsp_wait_req", bus.imem_req_valid, 0);
        end
        bus.pc_update_valid = 1'b0;
        bus.imem_rsp_valid  = 1'b1;
        bus.imem_rsp_data   = data;
        bus.imem_rsp_err    = err;
        if (!err) exp_dec_q.push_back('{pc: model_pc, ins: data, cnt: model_cnt});
        @(posedge clk); #1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_err   = 1'b0;
        if (err) begin
            check("err_fault", bus.fetch_fault, 1);
            check("err_ifu_valid", bus.ifu_valid, 0);
        end else begin
            model_ins = data;
            check("rsp_ifu_valid", bus.ifu_valid, 1);
            check("rsp_real_ins", bus.real_ins, data);
        end
    endtask

    task automatic do_transfer(input int hold, input bit force_pulse);
        if (hold > 0) bus.idu_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            bus.pc_update_valid = (force_pulse && i == 0) || coin(2);
            bus.next_pc         = $urandom;
            bus.imem_rsp_valid  = coin(2);
            bus.imem_rsp_data   = $urandom;
            @(posedge clk); #1;
            check("hold_ifu_valid", bus.ifu_valid, 1);
            check("hold_real_ins", bus.real_ins, model_ins);
            check("hold_pc", bus.pc, model_pc);
            check("hold_count", bus.fetch_count, model_cnt);
            check("hold_fault", bus.fetch_fault, 0);
        end
        bus.pc_update_valid = 1'b0;
        bus.imem_rsp_valid  = 1'b0;
        bus.idu_ready       = 1'b1;
        @(posedge clk); #1;
        model_cnt = model_cnt + 1'b1;
        check("xfer_ifu_valid", bus.ifu_valid, 0);
        check("xfer_count", bus.fetch_count, model_cnt);
        check("xfer_real_ins_kept", bus.real_ins, model_ins);
    endtask

    task automatic do_pc_update(input int delay, input logic [31:0] nxt);
        bit aligned;
        for (int i = 0; i < delay; i++) begin
            bus.pc_update_valid = 1'b0;
            bus.next_pc         = $urandom;
            bus.imem_rsp_valid  = coin(2);
            bus.imem_rsp_data   = $urandom;
            @(posedge clk); #1;
            check("wpc_req_valid", bus.imem_req_valid, 0);
            check("wpc_ifu_valid", bus.ifu_valid, 0);
            check("wpc_pc", bus.pc, model_pc);
        end
        bus.imem_rsp_valid  = 1'b0;
        bus.pc_update_valid = 1'b1;
        bus.next_pc         = nxt;
        aligned = (nxt[1:0] == 2'b00);
        if (aligned) exp_req_q.push_back(nxt);
        @(posedge clk); #1;
        bus.pc_update_valid = 1'b0;
        if (aligned) begin
            model_pc = nxt;
            check("upd_pc", bus.pc, nxt);
            check("upd_req_valid", bus.imem_req_valid, 1);
        end else begin
            check("mis_fault", bus.fetch_fault, 1);
            check("mis_pc_kept", bus.pc, model_pc);
            check("mis_req_valid", bus.imem_req_valid, 0);
        end
    endtask

    task automatic check_fault_idle(input int n);
        logic [31:0] r;
        for (int i = 0; i < n; i++) begin
            r = $urandom;
            bus.imem_req_ready  = coin(2);
            bus.imem_rsp_valid  = coin(2);
            bus.imem_rsp_err    = coin(2);
            bus.imem_rsp_data   = $urandom;
            bus.idu_ready       = coin(2);
            bus.pc_update_valid = coin(2);
            bus.next_pc         = {r[31:2], 2'b00};
            @(posedge clk); #1;
            check("flt_sticky", bus.fetch_fault, 1);
            check("flt_ifu_valid", bus.ifu_valid, 0);
            check("flt_req_valid", bus.imem_req_valid, 0);
            check("flt_pc", bus.pc, model_pc);
            check("flt_count", bus.fetch_count, model_cnt);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [31:0] r;
        logic [31:0] nxt;

        bus.imem_req_ready  = 1'b0;
        bus.imem_rsp_valid  = 1'b0;
        bus.imem_rsp_data   = '0;
        bus.imem_rsp_err    = 1'b0;
        bus.idu_ready       = 1'b0;
        bus.pc_update_valid = 1'b0;
        bus.next_pc         = '0;
        repeat (2) @(posedge clk);
        #1;

        // First fetch after reset with minimum response latency.
        do_reset(1, 1'b0);
        do_request(0);
        do_response(0, 32'h0000_0013, 1'b0);
        do_transfer(0, 1'b0);

        // Memory stalls the request for five cycles.
        do_reset(1, 1'b0);
        do_request(5);
        do_response(1, 32'h1234_5678, 1'b0);
        // Decode stalls for four cycles while a PC update is offered.
        do_transfer(4, 1'b1);
        do_pc_update(2, 32'h8000_0010);
        do_request(0);
        do_response(0, 32'hdead_beef, 1'b0);
        do_transfer(0, 1'b0);
        do_pc_update(0, 32'h8000_0012);
        check_fault_idle(4);

        // Bus error, then recovery through reset.
        do_reset(1, 1'b0);
        do_request(0);
        do_response(0, 32'hffff_ffff, 1'b1);
        check_fault_idle(3);
        do_reset(1, 1'b0);

        // Reset with a request outstanding, late response after release.
        do_request(0);
        do_reset(2, 1'b1);
        do_request(0);
        do_response(0, 32'h0000_0093, 1'b0);
        do_transfer(1, 1'b0);
        do_pc_update(0, RESET_PC + 32'd4);

        for (int n = 0; n < 300; n++) begin
            do_request($urandom_range(0, 3));
            if (coin(20)) begin
                do_reset($urandom_range(1, 2), coin(2));
                continue;
            end
            if (coin(20)) begin
                do_response($urandom_range(0, 3), $urandom, 1'b1);
                check_fault_idle(3);
                do_reset(1, 1'b0);
                continue;
            end
            do_response($urandom_range(0, 3), $urandom, 1'b0);
            do_transfer($urandom_range(0, 3), 1'b0);
            r = $urandom;
            if (coin(16)) begin
                nxt = {r[31:2], 2'($urandom_range(1, 3))};
                do_pc_update($urandom_range(0, 2), nxt);
                check_fault_idle(2);
                do_reset(1, 1'b0);
            end else begin
                nxt = coin(2) ? model_pc + 32'd4 : {r[31:2], 2'b00};
                do_pc_update($urandom_range(0, 2), nxt);
            end
        end

        @(negedge clk);
        check("dec_queue_drained", 64'(exp_dec_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
